// File: rtl/parity_sched_pkg.sv
// Shared types and helpers for the parity count scheduler.
// Holds FSM encodings, parity constants and small datapath helpers.
package parity_sched_pkg;

   localparam int unsigned LEN_W = 4;
   localparam int unsigned REM_W = LEN_W + 1;

   localparam logic PARITY_ODD  = 1'b1;
   localparam logic PARITY_EVEN = 1'b0;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_e;

   localparam logic [REM_W-1:0] REM_ZERO = {REM_W{1'b0}};
   localparam logic [REM_W-1:0] REM_ONE  = {{(REM_W-1){1'b0}}, 1'b1};

   // A zero length field encodes the maximum burst of 2**LEN_W counts.
   function automatic logic [REM_W-1:0] decode_len(input logic [LEN_W-1:0] len);
      if (len == {LEN_W{1'b0}}) begin
         decode_len = {1'b1, {LEN_W{1'b0}}};
      end else begin
         decode_len = {1'b0, len};
      end
   endfunction

   function automatic logic [1:0] next_count(input logic msb, input logic par);
      next_count = {~msb, par};
   endfunction

   function automatic logic arb_pick(input logic req_o, input logic req_e, input logic last);
      if (req_o && req_e) begin
         arb_pick = ~last;
      end else if (req_o) begin
         arb_pick = PARITY_ODD;
      end else begin
         arb_pick = PARITY_EVEN;
      end
   endfunction

endpackage

// File: rtl/parity_count_scheduler_chk.sv
// Invariant checker for the scheduler outputs; no effect on hardware.
module parity_count_scheduler_chk (
   input logic clk,
   input logic rst,
   input logic gnt_odd,
   input logic gnt_even,
   input logic count_valid,
   input logic done,
   input logic busy
);

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
      !(gnt_odd && gnt_even));

   a_valid_tracks_grant: assert property (@(posedge clk) disable iff (rst)
      count_valid == (gnt_odd || gnt_even));

   a_done_quiet: assert property (@(posedge clk) disable iff (rst)
      done |-> (!count_valid && busy));

endmodule

// File: rtl/parity_counter.sv
// Two-bit parity counter: low bit pinned to the burst parity, high bit toggles.
module parity_counter
   import parity_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       en,
   input  logic       select,
   output logic [1:0] count
);

   logic [1:0] count_d;
   logic [1:0] count_q;

   // Load restarts the sequence at the parity value; enable advances it.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = {1'b0, select};
      end else if (en) begin
         count_d = next_count(count_q[1], select);
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'b00;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/parity_count_scheduler.sv
// Round-robin scheduler granting parity bursts of a shared counter.
module parity_count_scheduler
   import parity_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_odd,
   input  logic       req_even,
   input  logic [3:0] burst_len,
   output logic       gnt_odd,
   output logic       gnt_even,
   output logic [1:0] count,
   output logic       count_valid,
   output logic       done,
   output logic       busy
);

   state_e           state_q, state_d;
   logic [REM_W-1:0] remaining_q, remaining_d;
   logic             parity_q, parity_d;
   logic             last_grant_q, last_grant_d;
   logic             gnt_odd_q, gnt_odd_d;
   logic             gnt_even_q, gnt_even_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic             any_req;
   logic             grant_par;
   logic             cnt_load;
   logic             cnt_en;
   logic             cnt_sel;

   assign any_req   = req_odd | req_even;
   assign grant_par = arb_pick(req_odd, req_even, last_grant_q);

   // Counter control: load on grant, advance while more counts remain.
   always_comb begin
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      cnt_sel  = parity_q;
      if ((state_q == S_IDLE) && any_req) begin
         cnt_load = 1'b1;
         cnt_sel  = grant_par;
      end else if ((state_q == S_RUN) && (remaining_q > REM_ONE)) begin
         cnt_en   = 1'b1;
      end else begin
         cnt_sel  = parity_q;
      end
   end

   // Next-state and registered-output logic; pulses default low each cycle.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      parity_d     = parity_q;
      last_grant_d = last_grant_q;
      gnt_odd_d    = 1'b0;
      gnt_even_d   = 1'b0;
      valid_d      = 1'b0;
      done_d       = 1'b0;
      busy_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d      = S_RUN;
               remaining_d  = decode_len(burst_len);
               parity_d     = grant_par;
               last_grant_d = grant_par;
               gnt_odd_d    = (grant_par == PARITY_ODD);
               gnt_even_d   = (grant_par == PARITY_EVEN);
               valid_d      = 1'b1;
               busy_d       = 1'b1;
            end else begin
               state_d      = S_IDLE;
            end
         end
         S_RUN: begin
            busy_d = 1'b1;
            if (remaining_q != REM_ZERO) begin
               remaining_d = remaining_q - REM_ONE;
            end else begin
               remaining_d = REM_ZERO;
            end
            if (remaining_q > REM_ONE) begin
               state_d    = S_RUN;
               gnt_odd_d  = (parity_q == PARITY_ODD);
               gnt_even_d = (parity_q == PARITY_EVEN);
               valid_d    = 1'b1;
            end else begin
               state_d    = S_DONE;
               done_d     = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d     = S_IDLE;
            remaining_d = REM_ZERO;
         end
      endcase
   end

   // State and output registers; reset abandons any burst without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         remaining_q  <= REM_ZERO;
         parity_q     <= PARITY_EVEN;
         last_grant_q <= PARITY_EVEN;
         gnt_odd_q    <= 1'b0;
         gnt_even_q   <= 1'b0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         parity_q     <= parity_d;
         last_grant_q <= last_grant_d;
         gnt_odd_q    <= gnt_odd_d;
         gnt_even_q   <= gnt_even_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   parity_counter u_counter (
      .clk    (clk),
      .rst    (rst),
      .load   (cnt_load),
      .en     (cnt_en),
      .select (cnt_sel),
      .count  (count)
   );

   parity_count_scheduler_chk u_chk (
      .clk         (clk),
      .rst         (rst),
      .gnt_odd     (gnt_odd_q),
      .gnt_even    (gnt_even_q),
      .count_valid (valid_q),
      .done        (done_q),
      .busy        (busy_q)
   );

   assign gnt_odd     = gnt_odd_q;
   assign gnt_even    = gnt_even_q;
   assign count_valid = valid_q;
   assign done        = done_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_parity_count_scheduler.sv
// Self-checking bench: directed bursts plus random traffic against a burst-level model.
module tb_parity_count_scheduler;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       req_odd   = 1'b0;
   logic       req_even  = 1'b0;
   logic [3:0] burst_len = 4'd0;
   logic       gnt_odd;
   logic       gnt_even;
   logic [1:0] count;
   logic       count_valid;
   logic       done;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   bit last_grant = 1'b0;

   always #5 clk = ~clk;

   parity_count_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .req_odd     (req_odd),
      .req_even    (req_even),
      .burst_len   (burst_len),
      .gnt_odd     (gnt_odd),
      .gnt_even    (gnt_even),
      .count       (count),
      .count_valid (count_valid),
      .done        (done),
      .busy        (busy)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph, input int go, input int ge, input int cv,
                            input int cnt, input int dn, input int bz, input bit with_cnt);
      chk({ph, "/gnt_odd"}, int'(gnt_odd), go);
      chk({ph, "/gnt_even"}, int'(gnt_even), ge);
      chk({ph, "/count_valid"}, int'(count_valid), cv);
      chk({ph, "/done"}, int'(done), dn);
      chk({ph, "/busy"}, int'(busy), bz);
      if (with_cnt) chk({ph, "/count"}, int'(count), cnt);
   endtask

   // One whole burst seen from the outside: N valid counts, a done cycle, an idle cycle.
   task automatic do_burst(input bit add_odd, input bit add_even, input logic [3:0] len,
                           input bit hold, input int abort_at, input bit perturb);
      bit par;
      int n;
      int last_val;
      req_odd   = req_odd | add_odd;
      req_even  = req_even | add_even;
      burst_len = len;
      if (req_odd && req_even) par = ~last_grant;
      else par = req_odd;
      last_grant = par;
      n = (len == 4'd0) ? 16 : int'(len);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check_all("run", int'(par), int'(!par), 1, int'(par) + 2 * (k % 2), 0, 1, 1'b1);
         if (k == 0 && !hold) begin
            if (par) req_odd = 1'b0;
            else req_even = 1'b0;
         end
         if (perturb && k == 1) begin
            burst_len = 4'd2;
            req_even  = 1'b1;
         end else if (!perturb && k >= 1) begin
            burst_len = 4'($urandom_range(0, 15));
         end
         if (k == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            check_all("abort", 0, 0, 0, 0, 0, 0, 1'b1);
            rst        = 1'b0;
            req_odd    = 1'b0;
            req_even   = 1'b0;
            last_grant = 1'b0;
            @(negedge clk);
            check_all("post_abort", 0, 0, 0, 0, 0, 0, 1'b1);
            return;
         end
      end
      last_val = int'(par) + 2 * ((n - 1) % 2);
      @(negedge clk);
      check_all("done", 0, 0, 0, last_val, 1, 1, 1'b1);
      @(negedge clk);
      check_all("gap", 0, 0, 0, last_val, 0, 0, 1'b1);
   endtask

   initial begin
      bit ro;
      bit re;
      // Reset and quiet idle
      @(negedge clk);
      check_all("reset", 0, 0, 0, 0, 0, 0, 1'b1);
      @(negedge clk);
      check_all("reset", 0, 0, 0, 0, 0, 0, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_all("idle", 0, 0, 0, 0, 0, 0, 1'b1);
      end

      // Single odd, single even
      do_burst(1'b1, 1'b0, 4'd4, 1'b0, -1, 1'b0);
      do_burst(1'b0, 1'b1, 4'd3, 1'b0, -1, 1'b0);

      // Contention with both requests held: odd, even, odd, even
      for (int i = 0; i < 4; i++) begin
         do_burst(1'b1, 1'b1, 4'd2, 1'b1, -1, 1'b0);
         chk("rr_order", int'(last_grant), (i % 2 == 0) ? 1 : 0);
      end
      req_odd  = 1'b0;
      req_even = 1'b0;

      // Length wrap and minimum length
      do_burst(1'b1, 1'b0, 4'd0, 1'b0, -1, 1'b0);
      do_burst(1'b0, 1'b1, 4'd0, 1'b0, -1, 1'b0);
      do_burst(1'b0, 1'b1, 4'd1, 1'b0, -1, 1'b0);

      // Mid-burst reset on the third RUN cycle, then contention must favour odd
      do_burst(1'b1, 1'b0, 4'd8, 1'b0, 2, 1'b0);
      do_burst(1'b1, 1'b1, 4'd3, 1'b0, -1, 1'b0);
      chk("post_reset_rr", int'(last_grant), 1);
      req_even = 1'b0;

      // Inputs changed during an odd burst are ignored
      do_burst(1'b1, 1'b0, 4'd5, 1'b0, -1, 1'b1);
      do_burst(1'b0, 1'b0, 4'd2, 1'b0, -1, 1'b0);
      chk("late_even_granted", int'(last_grant), 0);

      // Random traffic
      for (int i = 0; i < 24; i++) begin
         ro = 1'($urandom_range(0, 1));
         re = 1'($urandom_range(0, 1));
         if (!ro && !re && !req_odd && !req_even) ro = 1'b1;
         do_burst(ro, re, 4'($urandom_range(0, 15)), 1'b0, -1, 1'b0);
         if (!req_odd && !req_even && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            check_all("rand_idle", 0, 0, 0, 0, 0, 0, 1'b0);
         end
      end
      req_odd  = 1'b0;
      req_even = 1'b0;
      @(negedge clk);
      check_all("final_idle", 0, 0, 0, 0, 0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parity_count_scheduler.md
PARITY_COUNT_SCHEDULER -- requirements
Module: parity_count_scheduler

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port req_odd, input, 1, odd-parity requester wants a burst; held until its grant.
REQ-004 SHALL have port req_even, input, 1, even-parity requester wants a burst; held until its grant.
REQ-005 SHALL have port burst_len, input, 4, burst length in counts; 0 encodes 16; sampled at grant.
REQ-006 SHALL have port gnt_odd, output, 1, odd requester owns the counter.
REQ-007 SHALL have port gnt_even, output, 1, even requester owns the counter.
REQ-008 SHALL have port count, output, 2, current parity-counter value.
REQ-009 SHALL have port count_valid, output, 1, count holds a burst value this cycle.
REQ-010 SHALL have port done, output, 1, one-cycle end-of-burst pulse.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; encodings fixed in package.
REQ-013 In IDLE with no request, SHALL stay in IDLE with gnt_*, count_valid, done all 0.
REQ-014 In IDLE with exactly one request, SHALL grant that requester: next cycle RUN, matching gnt_* high.
REQ-015 In IDLE with both requests, SHALL grant the parity not granted last (round-robin); last_grant resets to even, so odd wins first contention.
REQ-016 On the IDLE->RUN edge, SHALL latch burst_len into remaining counter (0 -> 16), record granted parity, update last_grant.
REQ-017 On the IDLE->RUN edge, SHALL load count with {1'b0, parity}: first burst value 1 (odd) or 0 (even).
REQ-018 On each edge while in RUN and remaining > 1, SHALL update count to {~count[1], parity}: odd bursts 1,3,1,3...; even bursts 0,2,0,2...
REQ-019 SHALL keep count_valid and the granted gnt_* high for exactly N RUN cycles (N = latched length), and decrement remaining each RUN cycle.
REQ-020 On the last RUN cycle (remaining == 1), SHALL transition to DONE; count holds its last value.
REQ-021 In DONE, SHALL assert done for one cycle with gnt_* and count_valid low, then return to IDLE.
REQ-022 SHALL ignore request and burst_len changes while in RUN or DONE; arbitration occurs only in IDLE.
REQ-023 Minimum spacing between bursts SHALL be one DONE cycle plus one IDLE cycle.
REQ-024 gnt_odd and gnt_even SHALL never be high simultaneously.
REQ-025 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-026 On rst=1 at a clock edge, SHALL enter IDLE with count=0, remaining=0, gnt_*=0, count_valid=0, done=0, busy=0, last_grant=even.
REQ-027 Reset SHALL take priority over all other conditions, including mid-RUN; an aborted burst SHALL NOT produce a done pulse.

Structure
REQ-028 Shared package parity_sched_pkg SHALL hold the state enum, PARITY_ODD=1 / PARITY_EVEN=0 constants, and LEN_W=4.
REQ-029 The counter datapath SHALL be a sub-module parity_counter (clk, rst, load, en, select, count); the scheduler holds FSM, arbiter and length counter.

Verification
REQ-030 Single odd request: req_odd=1, burst_len=4 -> gnt_odd high 4 cycles, count 1,3,1,3 with count_valid, then done pulse; busy for 5 cycles.
REQ-031 Single even request: req_even=1, burst_len=3 -> count 0,2,0, then done; gnt_odd never high.
REQ-032 Contention: both requests held, burst_len=2 -> grants in order odd, even, odd, even; each burst 2 counts; done between each.
REQ-033 Length wrap: burst_len=0 -> 16 valid counts alternating per parity, then done; burst_len=1 -> one count, then done the next cycle.
REQ-034 Mid-burst reset: rst=1 on 3rd RUN cycle of an 8-count burst -> next cycle all outputs 0, no done pulse; next contention grants odd.
REQ-035 Input change during RUN: burst_len 5->2 and req_even raised mid odd burst -> odd burst still 5 counts; even granted only after DONE and IDLE.
